// File: rtl/spi_word_pkg.sv
// Shared definitions for the SPI word slave: FSM encoding and the command
// opcodes that the downstream command decoder recognises.
package spi_word_pkg;

  // Framing FSM states
  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    SETUP     = 2'd2,
    SHIFT     = 2'd3
  } spi_state_t;

  // Command opcodes carried in received words
  localparam logic [15:0] ZERO     = 16'h0000;
  localparam logic [15:0] SET_ACC  = 16'h0001;
  localparam logic [15:0] LOAD_ACC = 16'h0002;
  localparam logic [15:0] ADD      = 16'h0003;
  localparam logic [15:0] SUB      = 16'h0004;
  localparam logic [15:0] MUL      = 16'h0005;
  localparam logic [15:0] DIV      = 16'h0006;
  localparam logic [15:0] SUM      = 16'h0007;
  localparam logic [15:0] SUBS     = 16'h0008;
  localparam logic [15:0] END_MARK = 16'hFFFF;

endpackage

// File: rtl/spi_word_slave_fifo.sv
// Small synchronous FIFO with a registered head word, registered valid and
// registered not-full flag. A push into a full FIFO is accepted when a pop
// happens in the same cycle, since the pop frees the slot.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             in_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_EMPTY = CW'(0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_next_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             do_pop_s;
  logic             do_push_s;
  logic [WIDTH-1:0] head_next_s;

  // Accept decisions, next occupancy and next head word
  always_comb begin
    do_pop_s  = pop && head_valid;
    do_push_s = push && ((count_r != CNT_FULL) || do_pop_s);
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    rd_ptr_next_s = do_pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    // The incoming word becomes the head when it lands on the next read slot
    head_next_s = (do_push_s && (wr_ptr_r == rd_ptr_next_s)) ? push_data
                                                             : mem_r[rd_ptr_next_s];
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered head/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      head_data  <= '0;
      head_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      wr_ptr_r   <= do_push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r   <= rd_ptr_next_s;
      count_r    <= count_next_s;
      head_data  <= head_next_s;
      head_valid <= (count_next_s != CNT_EMPTY);
      in_ready   <= (count_next_s != CNT_FULL);
    end
  end

endmodule

// File: rtl/spi_word_slave.sv
// SPI slave framing front end: deserialises MOSI words into an RX FIFO and
// serialises TX FIFO words onto MISO, one bit per system clock edge, with
// burst frames, abort detection and a sticky RX overflow flag.
module spi_word_slave
  import spi_word_pkg::*;
#(
  parameter int                WORD_W    = 16,
  parameter bit                LSB_FIRST = 1'b1,
  parameter int                RX_DEPTH  = 4,
  parameter int                TX_DEPTH  = 4,
  parameter int                SS_SETUP  = 1,
  parameter logic [WORD_W-1:0] IDLE_WORD = {WORD_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_err,
  output logic              rx_overflow,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [1:0]       SETUP_LAST = 2'(SS_SETUP);

  spi_state_t        state_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [1:0]        setup_cnt_r;
  logic [WORD_W-1:0] rx_shift_r;
  logic [WORD_W-1:0] tx_shift_r;
  logic              miso_r;
  logic              frame_err_r;
  logic              rx_push_r;
  logic [WORD_W-1:0] rx_word_r;
  logic              rx_overflow_r;

  logic [CNT_W-1:0]  rx_bit_idx_s;
  logic [WORD_W-1:0] rx_next_s;
  logic              word_done_s;
  logic              word_start_s;
  logic [WORD_W-1:0] tx_load_word_s;
  logic              tx_first_bit_s;
  logic [WORD_W-1:0] tx_load_rest_s;
  logic              tx_next_bit_s;
  logic [WORD_W-1:0] tx_shift_next_s;
  logic              rx_drop_s;

  logic              rx_in_ready_s;
  logic [WORD_W-1:0] tx_head_data_s;
  logic              tx_head_valid_s;
  logic              tx_in_ready_s;

  // Bit steering for RX capture and TX load/advance in the configured order
  always_comb begin
    rx_bit_idx_s = LSB_FIRST ? bit_cnt_r : (LAST_BIT - bit_cnt_r);
    rx_next_s = rx_shift_r;
    rx_next_s[rx_bit_idx_s] = mosi;
    word_done_s  = (state_r == SHIFT) && !ss && (bit_cnt_r == LAST_BIT);
    word_start_s = ((state_r == IDLE) && !ss) || word_done_s;
    tx_load_word_s = tx_head_valid_s ? tx_head_data_s : IDLE_WORD;
    tx_first_bit_s = LSB_FIRST ? tx_load_word_s[0] : tx_load_word_s[WORD_W-1];
    tx_load_rest_s = LSB_FIRST ? {1'b0, tx_load_word_s[WORD_W-1:1]}
                               : {tx_load_word_s[WORD_W-2:0], 1'b0};
    tx_next_bit_s  = LSB_FIRST ? tx_shift_r[0] : tx_shift_r[WORD_W-1];
    tx_shift_next_s = LSB_FIRST ? {1'b0, tx_shift_r[WORD_W-1:1]}
                                : {tx_shift_r[WORD_W-2:0], 1'b0};
    // A completed word is lost only if the FIFO is full and not popping now
    rx_drop_s = rx_push_r && !rx_in_ready_s && !(rx_ready && rx_valid);
  end

  // Framing FSM with registered MISO, abort pulse and RX push strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= WAIT_HIGH;
      bit_cnt_r   <= '0;
      setup_cnt_r <= 2'd0;
      rx_shift_r  <= '0;
      tx_shift_r  <= '0;
      miso_r      <= 1'b0;
      frame_err_r <= 1'b0;
      rx_push_r   <= 1'b0;
      rx_word_r   <= '0;
    end else begin
      frame_err_r <= 1'b0;
      rx_push_r   <= 1'b0;
      case (state_r)
        WAIT_HIGH: begin
          // Never join a select that was already active when we came up
          miso_r    <= 1'b0;
          bit_cnt_r <= CNT_ZERO;
          state_r   <= ss ? IDLE : WAIT_HIGH;
        end
        IDLE: begin
          bit_cnt_r <= CNT_ZERO;
          if (!ss) begin
            tx_shift_r <= tx_load_rest_s;
            miso_r     <= tx_first_bit_s;
            if (SS_SETUP == 0) begin
              rx_shift_r <= rx_next_s;
              bit_cnt_r  <= CNT_ONE;
              state_r    <= SHIFT;
            end else begin
              setup_cnt_r <= 2'd1;
              state_r     <= SETUP;
            end
          end else begin
            miso_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SETUP: begin
          if (ss) begin
            miso_r  <= 1'b0;
            state_r <= IDLE;
          end else if (setup_cnt_r == SETUP_LAST) begin
            // Setup window done: this edge already carries bit 0
            rx_shift_r <= rx_next_s;
            bit_cnt_r  <= CNT_ONE;
            tx_shift_r <= tx_shift_next_s;
            miso_r     <= tx_next_bit_s;
            state_r    <= SHIFT;
          end else begin
            setup_cnt_r <= setup_cnt_r + 2'd1;
            state_r     <= SETUP;
          end
        end
        SHIFT: begin
          if (ss) begin
            // Rising select off a word boundary discards the partial word
            frame_err_r <= (bit_cnt_r != CNT_ZERO);
            bit_cnt_r   <= CNT_ZERO;
            miso_r      <= 1'b0;
            state_r     <= IDLE;
          end else if (word_done_s) begin
            rx_shift_r <= rx_next_s;
            rx_word_r  <= rx_next_s;
            rx_push_r  <= 1'b1;
            bit_cnt_r  <= CNT_ZERO;
            tx_shift_r <= tx_load_rest_s;
            miso_r     <= tx_first_bit_s;
            state_r    <= SHIFT;
          end else begin
            rx_shift_r <= rx_next_s;
            bit_cnt_r  <= bit_cnt_r + CNT_ONE;
            tx_shift_r <= tx_shift_next_s;
            miso_r     <= tx_next_bit_s;
            state_r    <= SHIFT;
          end
        end
        default: begin
          miso_r  <= 1'b0;
          state_r <= WAIT_HIGH;
        end
      endcase
    end
  end

  // Sticky overflow flag; a new drop outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow_r <= 1'b0;
    end else if (rx_drop_s) begin
      rx_overflow_r <= 1'b1;
    end else if (err_clr) begin
      rx_overflow_r <= 1'b0;
    end else begin
      rx_overflow_r <= rx_overflow_r;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rx_push_r),
    .push_data  (rx_word_r),
    .pop        (rx_ready),
    .head_data  (rx_data),
    .head_valid (rx_valid),
    .in_ready   (rx_in_ready_s)
  );

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (tx_valid && tx_in_ready_s),
    .push_data  (tx_data),
    .pop        (word_start_s),
    .head_data  (tx_head_data_s),
    .head_valid (tx_head_valid_s),
    .in_ready   (tx_in_ready_s)
  );

  assign miso        = miso_r;
  assign frame_err   = frame_err_r;
  assign rx_overflow = rx_overflow_r;
  assign tx_ready    = tx_in_ready_s;

endmodule
